// File: rtl/keypad_scan.sv
// 4x4 keypad scanner: steps one active-low row per scan tick, debounces a key press,
// and turns accepted keys into a decimal operand plus digit/enter/operation pulses.
//
// state    | meaning
// SCAN     | stepping rows each tick, looking for any low column
// DEBOUNCE | row frozen, counting stable ticks of the latched column
// HOLD     | key accepted, waiting for DEBOUNCE consecutive all-released ticks
module keypad_scan #(
    parameter int SCAN_DIV = 4096,
    parameter int DEBOUNCE = 4
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [7:0] ind_from_sw,
    output logic [1:0] keys,
    output logic [3:0] arifs,
    output logic       err
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

    typedef enum logic [1:0] {SCAN, DEBOUNCE_ST, HOLD} state_t;

    state_t           state;
    logic [3:0]       cols_meta;
    logic [3:0]       cols_sync;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [1:0]       col_idx;
    logic [CNT_W-1:0] cnt;
    logic             tick;
    logic [1:0]       low_col;
    logic             is_digit;
    logic             is_clear;
    logic             is_enter;
    logic [3:0]       digit;
    logic [11:0]      acc_next;

    assign tick = (div_cnt == DIV_LAST);

    // Lowest-index low column wins when several are pressed in the active row.
    always_comb begin
        low_col = 2'd0;
        for (int c = 3; c >= 0; c--) begin
            if (!cols_sync[c]) low_col = 2'(c);
        end
    end

    // Decode of the latched key; anything not digit/clear/enter is column 3 (operation).
    always_comb begin
        is_digit = 1'b0;
        is_clear = 1'b0;
        is_enter = 1'b0;
        digit    = 4'd0;
        if (col_idx != 2'd3) begin
            if (row_idx != 2'd3) begin
                is_digit = 1'b1;
                digit    = {2'b00, row_idx} * 4'd3 + {2'b00, col_idx} + 4'd1;
            end else if (col_idx == 2'd0) begin
                is_clear = 1'b1;
            end else if (col_idx == 2'd1) begin
                is_digit = 1'b1;
            end else begin
                is_enter = 1'b1;
            end
        end
    end

    assign acc_next = {4'd0, ind_from_sw} * 12'd10 + {8'd0, digit};

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= SCAN;
            cols_meta   <= 4'hF;
            cols_sync   <= 4'hF;
            div_cnt     <= '0;
            row_idx     <= 2'd0;
            col_idx     <= 2'd0;
            cnt         <= '0;
            rows        <= 4'b1110;
            ind_from_sw <= 8'd0;
            keys        <= 2'b00;
            arifs       <= 4'b0000;
            err         <= 1'b0;
        end else begin
            cols_meta <= cols;
            cols_sync <= cols_meta;
            div_cnt   <= tick ? '0 : div_cnt + DIV_W'(1);
            keys      <= 2'b00;
            arifs     <= 4'b0000;
            if (tick) begin
                case (state)
                    SCAN: begin
                        if (&cols_sync) begin
                            row_idx <= row_idx + 2'd1;
                            rows    <= ~(4'b0001 << (row_idx + 2'd1));
                        end else begin
                            col_idx <= low_col;
                            cnt     <= '0;
                            state   <= DEBOUNCE_ST;
                        end
                    end
                    DEBOUNCE_ST: begin
                        if (cols_sync[col_idx]) begin
                            state <= SCAN;
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= HOLD;
                            if (is_digit) begin
                                // 12-bit accumulate so overflow is seen before truncation.
                                if (acc_next <= 12'd255) begin
                                    ind_from_sw <= acc_next[7:0];
                                    keys        <= 2'b01;
                                end else begin
                                    err <= 1'b1;
                                end
                            end else if (is_clear) begin
                                ind_from_sw <= 8'd0;
                                err         <= 1'b0;
                            end else if (is_enter) begin
                                keys <= 2'b10;
                            end else begin
                                arifs <= 4'b0001 << row_idx;
                            end
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    HOLD: begin
                        if (!(&cols_sync)) begin
                            cnt <= '0;
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= SCAN;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: state <= SCAN;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad model drives cols from rows; expected pulses are queued
// as keys are pressed and matched against the DUT outputs on the falling edge.
module tb_keypad_scan;
    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] cols;
    logic [3:0] rows;
    logic [7:0] ind_from_sw;
    logic [1:0] keys;
    logic [3:0] arifs;
    logic       err;

    logic [15:0] pressed;
    logic [13:0] exp_q[$];
    logic [13:0] exp_val;
    int total = 0;
    int bad   = 0;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(2)) dut (
        .Clk(Clk), .Rst(Rst), .cols(cols), .rows(rows),
        .ind_from_sw(ind_from_sw), .keys(keys), .arifs(arifs), .err(err)
    );

    always #5 Clk = ~Clk;

    // Key index = row*4 + col; a pressed key pulls its column low while its row is driven.
    always_comb begin
        cols = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !rows[r]) cols[c] = 1'b0;
    end

    function automatic logic [13:0] ev(input logic [1:0] k, input logic [3:0] a, input logic [7:0] v);
        return {k, a, v};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input int k, input int hold_t, input int rel_t);
        pressed[k] = 1'b1;
        repeat (hold_t * 4) @(negedge Clk);
        pressed[k] = 1'b0;
        repeat (rel_t * 4) @(negedge Clk);
    endtask

    task automatic wait_rows(input logic [3:0] target, input string tag);
        bit found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge Clk);
            if (rows == target) found = 1;
        end
        chk(tag, 16'(found), 16'd1);
    endtask

    always @(negedge Clk) begin
        total++;
        assert ($countones(rows) == 3) else begin
            bad++;
            $error("FAIL rows_onehot observed=%b expected=one-low", rows);
        end
        total++;
        assert ($countones({keys, arifs}) <= 1) else begin
            bad++;
            $error("FAIL pulse_exclusive observed=%b expected=at-most-one", {keys, arifs});
        end
        if (keys != 2'b00 || arifs != 4'b0000) begin
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_pulse observed=%h expected=none", {keys, arifs, ind_from_sw});
            end
            if (exp_q.size() > 0) begin
                exp_val = exp_q.pop_front();
                total++;
                assert ({keys, arifs, ind_from_sw} === exp_val) else begin
                    bad++;
                    $error("FAIL pulse_value observed=%h expected=%h", {keys, arifs, ind_from_sw}, exp_val);
                end
            end
        end
    end

    initial begin
        logic [3:0] r0;
        bit moved;
        Rst = 1'b1;
        pressed = '0;
        repeat (3) @(negedge Clk);
        chk("reset_rows", 16'(rows), 16'h000E);
        chk("reset_ind", 16'(ind_from_sw), 16'd0);
        chk("reset_keys", 16'(keys), 16'd0);
        chk("reset_arifs", 16'(arifs), 16'd0);
        chk("reset_err", 16'(err), 16'd0);
        Rst = 1'b0;

        // digits 1, 2, 5 -> 125
        exp_q.push_back(ev(2'b01, 4'b0, 8'd1));   press(0, 10, 4);
        exp_q.push_back(ev(2'b01, 4'b0, 8'd12));  press(1, 10, 4);
        exp_q.push_back(ev(2'b01, 4'b0, 8'd125)); press(5, 10, 4);
        chk("ind_125", 16'(ind_from_sw), 16'd125);
        chk("err_clear_125", 16'(err), 16'd0);

        // 1256 overflows: value holds, err sets, then '*' clears both
        press(6, 10, 4);
        chk("overflow_ind", 16'(ind_from_sw), 16'd125);
        chk("overflow_err", 16'(err), 16'd1);
        press(12, 10, 4);
        chk("clear_ind", 16'(ind_from_sw), 16'd0);
        chk("clear_err", 16'(err), 16'd0);

        // exactly 255 is accepted, 2550 is not
        exp_q.push_back(ev(2'b01, 4'b0, 8'd2));   press(1, 10, 4);
        exp_q.push_back(ev(2'b01, 4'b0, 8'd25));  press(5, 10, 4);
        exp_q.push_back(ev(2'b01, 4'b0, 8'd255)); press(5, 10, 4);
        chk("err_at_255", 16'(err), 16'd0);
        press(13, 10, 4);
        chk("ind_hold_255", 16'(ind_from_sw), 16'd255);
        chk("err_after_2550", 16'(err), 16'd1);
        press(12, 10, 4);

        // operation keys; C held 50 ticks gives a single pulse
        exp_q.push_back(ev(2'b00, 4'b0001, 8'd0)); press(3, 10, 4);
        exp_q.push_back(ev(2'b00, 4'b0010, 8'd0)); press(7, 10, 4);
        exp_q.push_back(ev(2'b00, 4'b1000, 8'd0)); press(15, 10, 4);
        exp_q.push_back(ev(2'b00, 4'b0100, 8'd0)); press(11, 50, 4);

        // key 7 bouncing one tick on, one tick off: never accepted
        for (int i = 0; i < 12; i++) press(8, 1, 1);
        repeat (8) @(negedge Clk);
        r0 = rows;
        moved = 0;
        for (int i = 0; i < 40 && !moved; i++) begin
            @(negedge Clk);
            if (rows != r0) moved = 1;
        end
        chk("scan_resumes", 16'(moved), 16'd1);
        chk("bounce_no_digit", 16'(ind_from_sw), 16'd0);

        // 4 and 6 together: lowest column (4) wins; then Enter
        exp_q.push_back(ev(2'b01, 4'b0, 8'd4));
        pressed[4] = 1'b1;
        pressed[6] = 1'b1;
        repeat (40) @(negedge Clk);
        pressed = '0;
        repeat (16) @(negedge Clk);
        exp_q.push_back(ev(2'b10, 4'b0, 8'd4)); press(14, 10, 4);
        chk("enter_hold_ind", 16'(ind_from_sw), 16'd4);

        // 49, then 499 overflows so err is set going into reset
        exp_q.push_back(ev(2'b01, 4'b0, 8'd49)); press(10, 10, 4);
        press(10, 10, 4);
        chk("pre_reset_err", 16'(err), 16'd1);

        // reset in the middle of debouncing key 9
        wait_rows(4'b1101, "reach_row1");
        pressed[10] = 1'b1;
        wait_rows(4'b1011, "reach_row2");
        repeat (6) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        chk("rst_rows", 16'(rows), 16'h000B ^ 16'h0005);
        chk("rst_ind", 16'(ind_from_sw), 16'd0);
        chk("rst_keys", 16'(keys), 16'd0);
        chk("rst_arifs", 16'(arifs), 16'd0);
        chk("rst_err", 16'(err), 16'd0);
        @(negedge Clk);
        // key still held through reset release: re-debounced, then accepted once
        exp_q.push_back(ev(2'b01, 4'b0, 8'd9));
        Rst = 1'b0;
        repeat (48) @(negedge Clk);
        pressed = '0;
        repeat (24) @(negedge Clk);
        chk("post_reset_ind", 16'(ind_from_sw), 16'd9);
        chk("queue_empty", 16'(exp_q.size()), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
